game_flow_ctrl: RTL and testbench



---
 rtl/game_flow_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game sequencer: COVER -> COUNTDOWN -> GAME -> DEAD, key decode, world reset/freeze.
// Optional pause on P in GAME is enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_ctrl #(
    parameter int COUNT_CYCLES = 100_000_000,
    parameter int COUNT_SECS   = 3,
    parameter int DEAD_CYCLES  = 200_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    input  logic         slime_die,
    output logic [1:0]   game_state,
    output logic         rst_game,
    output logic [1:0]   move_dir,
    output logic         jump,
    output logic [1:0]   countdown,
    output logic         freeze,
    output logic         paused
);

    localparam int MAX_CYC = (COUNT_CYCLES > DEAD_CYCLES) ? COUNT_CYCLES : DEAD_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] CNT_LAST  = TW'(COUNT_CYCLES - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYCLES - 1);

    localparam logic [8:0] KEY_ENTER   = 9'h05A;
    localparam logic [8:0] KEY_ENTER_X = 9'h15A;
    localparam logic [8:0] KEY_A       = 9'h01C;
    localparam logic [8:0] KEY_D       = 9'h023;
    localparam logic [8:0] KEY_SPACE   = 9'h029;
    localparam logic [8:0] KEY_P       = 9'h04D;

    typedef enum logic [1:0] {
        ST_COVER     = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_GAME      = 2'b10,
        ST_DEAD      = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    countdown_q, countdown_d;
    logic [1:0]    move_dir_q, move_dir_d;
    logic          rst_game_q, rst_game_d;
    logic          jump_q, jump_d;
    logic          freeze_q, freeze_d;
    logic          paused_q, paused_d;

    logic make;
    logic key_a, key_d;

    // Break events clear the key_down bit, so a make is a valid event on a held key.
    assign make  = key_valid && key_down[last_change];
    assign key_a = key_down[KEY_A];
    assign key_d = key_down[KEY_D];

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q + 1'b1;
        countdown_d = countdown_q;
        rst_game_d  = 1'b0;
        jump_d      = 1'b0;
        move_dir_d  = 2'b00;
        paused_d    = paused_q;

        case (state_q)
            ST_COVER: begin
                tick_d      = '0;
                countdown_d = 2'd0;
                if (make && (last_change == KEY_ENTER || last_change == KEY_ENTER_X)) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = 2'(COUNT_SECS);
                    rst_game_d  = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick_q == CNT_LAST) begin
                    tick_d      = '0;
                    countdown_d = countdown_q - 2'd1;
                    if (countdown_q == 2'd1) begin
                        state_d = ST_GAME;
                    end
                end
            end
            ST_GAME: begin
                tick_d = '0;
                // Death beats any key arriving in the same cycle.
                if (slime_die && !paused_q) begin
                    state_d  = ST_DEAD;
                    paused_d = 1'b0;
                end else begin
`ifdef GAME_FLOW_PAUSE_EN
                    if (make && last_change == KEY_P) begin
                        paused_d = !paused_q;
                    end
`endif
                    if (!paused_d) begin
                        move_dir_d = {key_a && !key_d, key_d && !key_a};
                        jump_d     = make && (last_change == KEY_SPACE);
                    end
                end
            end
            ST_DEAD: begin
                if (tick_q == DEAD_LAST) begin
                    state_d = ST_COVER;
                    tick_d  = '0;
                end
            end
            default: begin
                state_d = ST_COVER;
                tick_d  = '0;
            end
        endcase

`ifndef GAME_FLOW_PAUSE_EN
        paused_d = 1'b0;
`endif
        freeze_d = !(state_d == ST_GAME && !paused_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COVER;
            tick_q      <= '0;
            countdown_q <= 2'd0;
            rst_game_q  <= 1'b0;
            move_dir_q  <= 2'b00;
            jump_q      <= 1'b0;
            freeze_q    <= 1'b1;
            paused_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            countdown_q <= countdown_d;
            rst_game_q  <= rst_game_d;
            move_dir_q  <= move_dir_d;
            jump_q      <= jump_d;
            freeze_q    <= freeze_d;
            paused_q    <= paused_d;
        end
    end

    assign game_state = state_q;
    assign rst_game   = rst_game_q;
    assign move_dir   = move_dir_q;
    assign jump       = jump_q;
    assign countdown  = countdown_q;
    assign freeze     = freeze_q;
    assign paused     = paused_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed and randomized bench for game_flow_ctrl against a phase/elapsed-time model.
module tb_game_flow_ctrl;

    localparam int CC = 4;
    localparam int CS = 3;
    localparam int DC = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [8:0]   last_change = 9'h000;
    logic [511:0] key_down = '0;
    logic         slime_die = 1'b0;
    logic [1:0]   game_state;
    logic         rst_game;
    logic [1:0]   move_dir;
    logic         jump;
    logic [1:0]   countdown;
    logic         freeze;
    logic         paused;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase number, cycles elapsed in the phase, pause flag and one-cycle outputs.
    int m_phase = 0;
    int m_t     = 0;
    bit m_paused = 0;
    bit m_rst_game = 0;
    bit m_jump = 0;
    int m_move = 0;

    logic [8:0] keys [7];

    game_flow_ctrl #(.COUNT_CYCLES(CC), .COUNT_SECS(CS), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .key_down(key_down), .slime_die(slime_die), .game_state(game_state),
        .rst_game(rst_game), .move_dir(move_dir), .jump(jump), .countdown(countdown),
        .freeze(freeze), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_tick();
        bit mk;
        bit a;
        bit d;
        mk = key_valid && key_down[last_change];
        m_rst_game = 0;
        m_jump     = 0;
        m_move     = 0;
        if (rst) begin
            m_phase  = 0;
            m_t      = 0;
            m_paused = 0;
            return;
        end
        case (m_phase)
            0: if (mk && (last_change == 9'h05A || last_change == 9'h15A)) begin
                m_phase    = 1;
                m_t        = 0;
                m_rst_game = 1;
            end
            1: begin
                m_t++;
                if (m_t == CS * CC) begin
                    m_phase = 2;
                    m_t     = 0;
                end
            end
            2: if (slime_die && !m_paused) begin
                m_phase  = 3;
                m_t      = 0;
                m_paused = 0;
            end else begin
`ifdef GAME_FLOW_PAUSE_EN
                if (mk && last_change == 9'h04D) m_paused = !m_paused;
`endif
                if (!m_paused) begin
                    a = key_down[9'h01C];
                    d = key_down[9'h023];
                    m_move = (a && !d) ? 2 : (d && !a) ? 1 : 0;
                    m_jump = mk && last_change == 9'h029;
                end
            end
            default: begin
                m_t++;
                if (m_t == DC) begin
                    m_phase = 0;
                    m_t     = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        int exp_cd;
        exp_cd = (m_phase == 1) ? CS - m_t / CC : 0;
        check("game_state", 32'(game_state), 32'(m_phase));
        check("rst_game", 32'(rst_game), 32'(m_rst_game));
        check("move_dir", 32'(move_dir), 32'(m_move));
        check("jump", 32'(jump), 32'(m_jump));
        check("countdown", 32'(countdown), 32'(exp_cd));
        check("freeze", 32'(freeze), 32'(!(m_phase == 2 && !m_paused)));
        check("paused", 32'(paused), 32'(m_paused));
    endtask

    task automatic cyc(input logic r, input logic kv, input logic [8:0] lc, input logic sd);
        rst         = r;
        key_valid   = kv;
        last_change = lc;
        slime_die   = sd;
        @(posedge clk);
        model_tick();
        @(negedge clk);
        compare_all();
        rst       = 1'b0;
        key_valid = 1'b0;
        slime_die = 1'b0;
    endtask

    task automatic enter_make();
        key_down[9'h05A] = 1'b1;
        cyc(0, 1, 9'h05A, 0);
        key_down[9'h05A] = 1'b0;
    endtask

    initial begin
        keys[0] = 9'h05A; keys[1] = 9'h15A; keys[2] = 9'h01C; keys[3] = 9'h023;
        keys[4] = 9'h029; keys[5] = 9'h04D; keys[6] = 9'h000;
        @(negedge clk);

        cyc(1, 0, 9'h000, 0);
        check("rst_state", 32'(game_state), 0);
        check("rst_freeze", 32'(freeze), 1);
        check("rst_countdown", 32'(countdown), 0);

        // Enter -> countdown 3,2,1 -> GAME
        enter_make();
        check("t1_state", 32'(game_state), 1);
        check("t1_rst_game", 32'(rst_game), 1);
        check("t1_cd3", 32'(countdown), 3);
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 9'h000, 0);
            if (i == 1) check("t1_rst_game_once", 32'(rst_game), 0);
            if (i == 4) check("t1_cd2", 32'(countdown), 2);
            if (i == 8) check("t1_cd1", 32'(countdown), 1);
            if (i == 11) check("t1_still_cd", 32'(game_state), 1);
        end
        check("t1_game", 32'(game_state), 2);
        check("t1_unfrozen", 32'(freeze), 0);

        // Movement from key levels
        key_down[9'h01C] = 1'b1; cyc(0, 0, 9'h000, 0); check("t2_left", 32'(move_dir), 2);
        key_down[9'h023] = 1'b1; cyc(0, 0, 9'h000, 0); check("t2_both", 32'(move_dir), 0);
        key_down[9'h01C] = 1'b0; cyc(0, 0, 9'h000, 0); check("t2_right", 32'(move_dir), 1);
        key_down = '0;           cyc(0, 0, 9'h000, 0); check("t2_none", 32'(move_dir), 0);

        // Jump on make only
        key_down[9'h029] = 1'b1; cyc(0, 1, 9'h029, 0); check("t3_jump", 32'(jump), 1);
        cyc(0, 0, 9'h000, 0); check("t3_jump_once", 32'(jump), 0);
        key_down[9'h029] = 1'b0; cyc(0, 1, 9'h029, 0); check("t3_break", 32'(jump), 0);

        // Death with simultaneous Space make; Enter ignored in DEAD
        key_down[9'h029] = 1'b1; key_down[9'h01C] = 1'b1;
        cyc(0, 1, 9'h029, 1);
        check("t4_nojump", 32'(jump), 0);
        check("t4_dead", 32'(game_state), 3);
        check("t4_move0", 32'(move_dir), 0);
        key_down = '0;
        key_down[9'h05A] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(0, (i == 1), 9'h05A, 0);
            check("t4_dead_len", 32'(game_state), (i < 5) ? 3 : 0);
        end
        key_down = '0;

        // rst mid-countdown; slime_die in COVER ignored
        enter_make();
        for (int i = 1; i <= 4; i++) cyc(0, 0, 9'h000, 0);
        check("t5_cd2", 32'(countdown), 2);
        cyc(1, 0, 9'h000, 0);
        check("t5_state", 32'(game_state), 0);
        check("t5_cd0", 32'(countdown), 0);
        check("t5_freeze", 32'(freeze), 1);
        cyc(0, 0, 9'h000, 1);
        check("t5_cover_die", 32'(game_state), 0);

`ifdef GAME_FLOW_PAUSE_EN
        enter_make();
        for (int i = 1; i <= 12; i++) cyc(0, 0, 9'h000, 0);
        key_down[9'h04D] = 1'b1; cyc(0, 1, 9'h04D, 0);
        check("t6_paused", 32'(paused), 1);
        check("t6_freeze", 32'(freeze), 1);
        key_down[9'h04D] = 1'b0; key_down[9'h01C] = 1'b1;
        cyc(0, 0, 9'h000, 1);
        check("t6_die_ignored", 32'(game_state), 2);
        check("t6_move0", 32'(move_dir), 0);
        key_down[9'h04D] = 1'b1; cyc(0, 1, 9'h04D, 0);
        check("t6_resume", 32'(paused), 0);
        check("t6_unfreeze", 32'(freeze), 0);
        key_down = '0;
`endif

        // Randomized traffic
        cyc(1, 0, 9'h000, 0);
        for (int n = 0; n < 4000; n++) begin
            logic [8:0] lc;
            logic       kv;
            if ($urandom_range(7) == 0) key_down[keys[$urandom_range(5)]] = 1'($urandom);
            kv = ($urandom_range(3) == 0);
            lc = ($urandom_range(6) == 6) ? 9'($urandom) : keys[$urandom_range(5)];
            if (kv) key_down[lc] = ($urandom_range(3) != 0);
            cyc(($urandom_range(499) == 0), kv, lc, ($urandom_range(39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
